// File: rtl/pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl: scoreboard, forwarding, load-use/branch hazards and    |
// | memory-handshake freeze for the 5-stage core.        Revision: 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int MEM_TIMEOUT    = 16,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] rs1d,
   input  logic [REG_ADDR_WIDTH-1:0] rs2d,
   input  logic [REG_ADDR_WIDTH-1:0] rdd,
   input  logic                      regwrited,
   input  logic                      loadd,
   input  logic [REG_ADDR_WIDTH-1:0] rs1e,
   input  logic [REG_ADDR_WIDTH-1:0] rs2e,
   input  logic                      pcsrce,
   input  logic                      mem_req_m,
   input  logic                      mem_ack,
   output logic                      stallf,
   output logic                      stalld,
   output logic                      stall_em,
   output logic                      flushd,
   output logic                      flushe,
   output logic                      bubble_w,
   output logic [1:0]                forwardae,
   output logic [1:0]                forwardbe,
   output logic                      mem_err,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } mem_state_t;

   mem_state_t                state_q, state_d;
   logic [WCNT_W-1:0]         wcnt_q, wcnt_d;
   logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
   logic [REG_ADDR_WIDTH-1:0] rd_e_q, rd_e_d, rd_m_q, rd_m_d, rd_w_q, rd_w_d;
   logic                      we_e_q, we_e_d, we_m_q, we_m_d, we_w_q, we_w_d;
   logic                      ld_e_q, ld_e_d, ld_m_q, ld_m_d;
   logic                      mem_stall;
   logic                      load_use;

   assign mem_stall = (mem_req_m && !mem_ack && (state_q != ST_ERR)) || (state_q == ST_ERR);
   assign load_use  = ld_e_q && we_e_q && (rd_e_q != '0) && ((rd_e_q == rs1d) || (rd_e_q == rs2d));
   assign mem_err   = (state_q == ST_ERR);
   assign stall_cnt = stall_cnt_q;

   // A load in M has no data yet, so only W can supply its result.
   always_comb begin
      forwardae = 2'b00;
      forwardbe = 2'b00;
      if ((rs1e != '0) && we_m_q && (rd_m_q == rs1e) && !ld_m_q) forwardae = 2'b10;
      else if ((rs1e != '0) && we_w_q && (rd_w_q == rs1e))      forwardae = 2'b01;
      if ((rs2e != '0) && we_m_q && (rd_m_q == rs2e) && !ld_m_q) forwardbe = 2'b10;
      else if ((rs2e != '0) && we_w_q && (rd_w_q == rs2e))      forwardbe = 2'b01;
   end

   always_comb begin
      stallf   = 1'b0;
      stalld   = 1'b0;
      stall_em = 1'b0;
      flushd   = 1'b0;
      flushe   = 1'b0;
      bubble_w = 1'b0;
      if (mem_stall) begin
         stallf   = 1'b1;
         stalld   = 1'b1;
         stall_em = 1'b1;
         bubble_w = 1'b1;
      end else if (pcsrce) begin
         flushd = 1'b1;
         flushe = 1'b1;
      end else if (load_use) begin
         stallf = 1'b1;
         stalld = 1'b1;
         flushe = 1'b1;
      end
   end

   always_comb begin
      rd_e_d = rd_e_q;
      we_e_d = we_e_q;
      ld_e_d = ld_e_q;
      rd_m_d = rd_m_q;
      we_m_d = we_m_q;
      ld_m_d = ld_m_q;
      rd_w_d = rd_w_q;
      we_w_d = we_w_q;
      if (mem_stall) begin
         we_w_d = 1'b0;
      end else begin
         if (flushe) begin
            rd_e_d = '0;
            we_e_d = 1'b0;
            ld_e_d = 1'b0;
         end else begin
            rd_e_d = rdd;
            we_e_d = regwrited;
            ld_e_d = loadd;
         end
         rd_m_d = rd_e_q;
         we_m_d = we_e_q;
         ld_m_d = ld_e_q;
         rd_w_d = rd_m_q;
         we_w_d = we_m_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      stall_cnt_d = stall_cnt_q;
      if (stallf && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      case (state_q)
         ST_IDLE: begin
            if (mem_req_m && !mem_ack) begin
               state_d = ST_WAIT;
               wcnt_d  = WCNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (mem_ack)                  state_d = ST_IDLE;
            else if (wcnt_q == WCNT_LAST) state_d = ST_ERR;
            else                          wcnt_d  = wcnt_q + WCNT_W'(1);
         end
         ST_ERR:  state_d = ST_ERR;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= '0;
         stall_cnt_q <= '0;
         rd_e_q      <= '0;
         we_e_q      <= 1'b0;
         ld_e_q      <= 1'b0;
         rd_m_q      <= '0;
         we_m_q      <= 1'b0;
         ld_m_q      <= 1'b0;
         rd_w_q      <= '0;
         we_w_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         rd_e_q      <= rd_e_d;
         we_e_q      <= we_e_d;
         ld_e_q      <= ld_e_d;
         rd_m_q      <= rd_m_d;
         we_m_q      <= we_m_d;
         ld_m_q      <= ld_m_d;
         rd_w_q      <= rd_w_d;
         we_w_q      <= we_w_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl: directed vectors with a queued expected-response    |
// | scoreboard for pipe_hazard_ctrl.                     Revision: 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  rs1d = '0, rs2d = '0, rdd = '0, rs1e = '0, rs2e = '0;
   logic        regwrited = 1'b0, loadd = 1'b0, pcsrce = 1'b0;
   logic        mem_req_m = 1'b0, mem_ack = 1'b0;
   logic        stallf, stalld, stall_em, flushd, flushe, bubble_w, mem_err;
   logic [1:0]  forwardae, forwardbe;
   logic [15:0] stall_cnt;

   pipe_hazard_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(16), .CNT_WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .rs1d(rs1d), .rs2d(rs2d), .rdd(rdd), .regwrited(regwrited), .loadd(loadd),
      .rs1e(rs1e), .rs2e(rs2e), .pcsrce(pcsrce),
      .mem_req_m(mem_req_m), .mem_ack(mem_ack),
      .stallf(stallf), .stalld(stalld), .stall_em(stall_em),
      .flushd(flushd), .flushe(flushe), .bubble_w(bubble_w),
      .forwardae(forwardae), .forwardbe(forwardbe),
      .mem_err(mem_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [10:0] ctrl;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   passes = 0;
   bit   done = 1'b0;
   bit   reported = 1'b0;

   // {stallf,stalld,stall_em,flushd,flushe,bubble_w,forwardae,forwardbe,mem_err}
   function automatic logic [10:0] ctl(input logic sf, sd, sem, fd, fe, bw,
                                       input logic [1:0] fa, fb, input logic me);
      return {sf, sd, sem, fd, fe, bw, fa, fb, me};
   endfunction

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic [4:0] i_rs1d, i_rs2d, i_rdd, input logic i_wd, i_ld,
                      input logic [4:0] i_rs1e, i_rs2e, input logic i_pc, i_req, i_ack);
      rs1d = i_rs1d; rs2d = i_rs2d; rdd = i_rdd; regwrited = i_wd; loadd = i_ld;
      rs1e = i_rs1e; rs2e = i_rs2e; pcsrce = i_pc; mem_req_m = i_req; mem_ack = i_ack;
   endtask

   task automatic push(input string n, input logic [10:0] c, input logic [15:0] cnt);
      exp_t e;
      e.name = n; e.ctrl = c; e.cnt = cnt;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [10:0] got;
      got = {stallf, stalld, stall_em, flushd, flushe, bubble_w, forwardae, forwardbe, mem_err};
      if (done && !reported) begin
         checks++;
         if (sb.size() == 0) passes++;
         else $display("FAIL drain: %0d entries left, required 0", sb.size());
         reported = 1'b1;
      end else if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (got === e.ctrl) passes++;
         else $display("FAIL %s ctrl: got %b required %b", e.name, got, e.ctrl);
         checks++;
         if (stall_cnt === e.cnt) passes++;
         else $display("FAIL %s stall_cnt: got %0d required %0d", e.name, stall_cnt, e.cnt);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   initial begin
      logic [10:0] z;
      z = '0;
      repeat (2) @(posedge clk);
      #1;
      push("reset", z, 16'd0);

      // forwarding from M then W
      nxt(); rst = 1'b0;
      drv(0, 0, 5, 1, 0, 0, 0, 0, 0, 0); push("fwd_a", z, 0);
      nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("fwd_b", z, 0);
      nxt(); drv(0, 0, 0, 0, 0, 5, 5, 0, 0, 0); push("fwd_m", ctl(0,0,0,0,0,0,2'b10,2'b10,0), 0);
      nxt(); drv(0, 0, 0, 0, 0, 5, 5, 0, 0, 0); push("fwd_w", ctl(0,0,0,0,0,0,2'b01,2'b01,0), 0);
      nxt(); drv(0, 0, 0, 0, 0, 5, 0, 0, 0, 0); push("fwd_gone", z, 0);

      // load-use stall then W forward
      nxt(); drv(0, 0, 6, 1, 1, 0, 0, 0, 0, 0); push("lu_load", z, 0);
      nxt(); drv(0, 6, 7, 1, 0, 0, 0, 0, 0, 0); push("lu_stall", ctl(1,1,0,0,1,0,2'b00,2'b00,0), 0);
      nxt(); drv(0, 6, 7, 1, 0, 0, 0, 0, 0, 0); push("lu_release", z, 1);
      nxt(); drv(0, 0, 0, 0, 0, 0, 6, 0, 0, 0); push("lu_fwd_w", ctl(0,0,0,0,0,0,2'b00,2'b01,0), 1);

      // branch beats load-use; a load in M is never forwarded
      nxt(); drv(0, 0, 6, 1, 1, 0, 0, 0, 0, 0); push("br_load", z, 1);
      nxt(); drv(6, 0, 8, 1, 0, 0, 0, 1, 0, 0); push("br_flush", ctl(0,0,0,1,1,0,2'b00,2'b00,0), 1);
      nxt(); drv(0, 0, 0, 0, 0, 6, 0, 0, 0, 0); push("ld_in_m", z, 1);
      nxt(); drv(0, 0, 0, 0, 0, 6, 0, 0, 0, 0); push("ld_in_w", ctl(0,0,0,0,0,0,2'b01,2'b00,0), 1);

      // x0 is never a hazard or forward source
      nxt(); drv(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); push("x0_a", z, 1);
      nxt(); drv(0, 0, 0, 1, 0, 0, 0, 0, 0, 0); push("x0_no_lu", z, 1);
      nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("x0_m", z, 1);
      nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("x0_w", z, 1);

      nxt(); rst = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); push("reset2", z, 0);

      // memory wait acked after three stalled cycles; branch ignored while frozen
      nxt(); rst = 1'b0;
      drv(0, 0, 10, 1, 0, 0, 0, 0, 0, 0); push("mem_x10", z, 0);
      nxt(); drv(0, 0, 9, 1, 0, 0, 0, 0, 0, 0); push("mem_x9", z, 0);
      nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); push("mem_nop", z, 0);
      nxt(); drv(0, 0, 0, 0, 0, 9, 10, 1, 1, 0); push("mem_s0", ctl(1,1,1,0,0,1,2'b10,2'b01,0), 0);
      nxt(); drv(0, 0, 0, 0, 0, 9, 10, 1, 1, 0); push("mem_s1", ctl(1,1,1,0,0,1,2'b10,2'b00,0), 1);
      nxt(); drv(0, 0, 0, 0, 0, 9, 10, 1, 1, 0); push("mem_s2", ctl(1,1,1,0,0,1,2'b10,2'b00,0), 2);
      nxt(); drv(0, 0, 0, 0, 0, 9, 10, 1, 1, 1); push("mem_ack", ctl(0,0,0,1,1,0,2'b10,2'b00,0), 3);
      nxt(); drv(0, 0, 0, 0, 0, 9, 10, 0, 0, 0); push("mem_after", ctl(0,0,0,0,0,0,2'b01,2'b00,0), 3);

      nxt(); rst = 1'b1; drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nxt(); push("reset3", z, 0);

      // timeout: error rises in cycle 16 and stays after the request drops
      for (int i = 0; i < 20; i++) begin
         nxt(); rst = 1'b0;
         drv(0, 0, 0, 0, 0, 0, 0, 0, (i < 17), 0);
         push($sformatf("tmo_%0d", i), ctl(1,1,1,0,0,1,2'b00,2'b00,(i >= 16)), 16'(i));
      end

      nxt(); rst = 1'b1;
      nxt(); push("err_rst", z, 0);
      nxt(); rst = 1'b0; push("err_clear", z, 0);

      nxt(); done = 1'b1;
      repeat (3) @(posedge clk);
      if (!reported) begin
         checks++;
         $display("FAIL drain: monitor did not report, required report");
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

`default_nettype wire
